cache_refill_ctrl: RTL

Sequential controller for the set-associative read cache; it wraps the combinational tag-compare stage and consumes its `hit`, `miss` and `hit_way` outputs. It accepts one CPU line-read request at a time and registers the tag and index that drive the compare. On a hit it returns the array line. On a miss it picks a victim way, fetches the line from memory, writes it into the tag and data arrays, and then responds.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_refill_ctrl_victim_select.sv | 59 +++++
 rtl/cache_refill_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and default geometry for the read-cache refill controller.
package cache_pkg;

    // Default cache geometry; the modules take these as parameter defaults.
    localparam int N_WAYS      = 2;
    localparam int N_POW       = 4;
    localparam int TAG_BITS    = 21;
    localparam int INDEX_BITS  = 6;
    localparam int OFFSET_BITS = 5;
    localparam int LINE_BITS   = 256;
    localparam int ADDR_BITS   = TAG_BITS + INDEX_BITS + OFFSET_BITS;

    // Refill controller states.
    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        FILL,
        RESP
    } refill_state_t;

endpackage

// File: rtl/cache_refill_ctrl_victim_select.sv
// Victim way selection: the lowest-indexed empty way wins, otherwise the
// per-set round-robin pointer is used. The pointer only moves when a victim
// that came from it is actually filled, which gives FIFO replacement.
module victim_select #(
    parameter int N_WAYS     = cache_pkg::N_WAYS,
    parameter int N_POW      = cache_pkg::N_POW,
    parameter int INDEX_BITS = cache_pkg::INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] index,
    input  logic [N_WAYS-1:0]     line_empty,
    input  logic                  advance,
    output logic [N_POW-1:0]      victim,
    output logic                  victim_from_ptr
);

    localparam int N_SETS = 1 << INDEX_BITS;

    logic [N_POW-1:0]  ptr_reg [N_SETS];
    logic [N_WAYS-1:0] first_empty;

    // One-hot marker of the lowest empty way: a way qualifies when it is empty
    // and no lower-indexed way is empty.
    generate
        for (genvar gi = 0; gi < N_WAYS; gi++) begin : g_first_empty
            localparam logic [N_WAYS-1:0] LOWER_MASK = N_WAYS'((1 << gi) - 1);
            assign first_empty[gi] = line_empty[gi] & ~(|(line_empty & LOWER_MASK));
        end
    endgenerate

    // Encode the chosen way; fall back to the set's pointer when the set is full.
    always_comb begin
        victim          = ptr_reg[index];
        victim_from_ptr = 1'b1;
        for (int i = 0; i < N_WAYS; i++) begin
            if (first_empty[i]) begin
                victim          = N_POW'(i);
                victim_from_ptr = 1'b0;
            end
        end
    end

    // Round-robin pointer table; advances by one and wraps at N_WAYS-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < N_SETS; s++) begin
                ptr_reg[s] <= '0;
            end
        end else if (advance) begin
            if (ptr_reg[index] == N_POW'(N_WAYS - 1)) begin
                ptr_reg[index] <= '0;
            end else begin
                ptr_reg[index] <= ptr_reg[index] + N_POW'(1);
            end
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Refill controller for the set-associative read cache. Accepts one CPU line
// read at a time, drives the tag-compare stage with the registered request
// fields, answers hits from the data array and services misses by fetching
// the line from memory and writing it into the chosen victim way.
module cache_refill_ctrl #(
    parameter int N_WAYS       = cache_pkg::N_WAYS,
    parameter int N_POW        = cache_pkg::N_POW,
    parameter int TAG_BITS     = cache_pkg::TAG_BITS,
    parameter int INDEX_BITS   = cache_pkg::INDEX_BITS,
    parameter int OFFSET_BITS  = cache_pkg::OFFSET_BITS,
    parameter int LINE_BITS    = cache_pkg::LINE_BITS,
    localparam int ADDR        = TAG_BITS + INDEX_BITS + OFFSET_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    // CPU request / response
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic [ADDR-1:0]       cpu_req_addr,
    output logic                  cpu_rsp_valid,
    input  logic                  cpu_rsp_ready,
    output logic [LINE_BITS-1:0]  cpu_rsp_data,
    // Tag-compare stage and arrays
    output logic [TAG_BITS-1:0]   lookup_tag,
    output logic [INDEX_BITS-1:0] lookup_index,
    input  logic                  hit,
    input  logic                  miss,
    input  logic [N_POW-1:0]      hit_way,
    input  logic [N_WAYS-1:0]     line_empty,
    input  logic [LINE_BITS-1:0]  rd_data,
    // Memory fetch
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR-1:0]       mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [LINE_BITS-1:0]  mem_rsp_data,
    // Array write
    output logic                  fill_en,
    output logic [N_POW-1:0]      fill_way,
    output logic [INDEX_BITS-1:0] fill_index,
    output logic [TAG_BITS-1:0]   fill_tag,
    output logic [LINE_BITS-1:0]  fill_data
);

    import cache_pkg::*;

    refill_state_t          state_reg;
    refill_state_t          state_next;
    logic [TAG_BITS-1:0]    lookup_tag_reg;
    logic [INDEX_BITS-1:0]  lookup_index_reg;
    logic [LINE_BITS-1:0]   buf_reg;
    logic [N_POW-1:0]       victim_reg;
    logic                   victim_ptr_reg;
    logic [N_POW-1:0]       sel_victim;
    logic                   sel_from_ptr;
    logic                   ptr_advance;

    // The byte offset is irrelevant for whole-line transfers, and the data
    // array already applies hit_way when it presents rd_data.
    logic unused_inputs;
    assign unused_inputs = ^{cpu_req_addr[OFFSET_BITS-1:0], hit_way};

    // Pointer only moves on the fill of a victim that the pointer itself chose.
    assign ptr_advance = (state_reg == FILL) && victim_ptr_reg;

    victim_select #(
        .N_WAYS     (N_WAYS),
        .N_POW      (N_POW),
        .INDEX_BITS (INDEX_BITS)
    ) u_victim_select (
        .clk             (clk),
        .rst             (rst),
        .index           (lookup_index_reg),
        .line_empty      (line_empty),
        .advance         (ptr_advance),
        .victim          (sel_victim),
        .victim_from_ptr (sel_from_ptr)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next    = state_reg;
        cpu_req_ready = 1'b0;
        cpu_rsp_valid = 1'b0;
        mem_req_valid = 1'b0;
        fill_en       = 1'b0;
        case (state_reg)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    state_next = RESP;
                end else if (miss) begin
                    state_next = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_rsp_valid) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                fill_en    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                cpu_rsp_valid = 1'b1;
                if (cpu_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request fields, line buffer and latched victim.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_tag_reg   <= '0;
            lookup_index_reg <= '0;
            buf_reg          <= '0;
            victim_reg       <= '0;
            victim_ptr_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cpu_req_valid) begin
                        lookup_tag_reg   <= cpu_req_addr[ADDR-1 -: TAG_BITS];
                        lookup_index_reg <= cpu_req_addr[OFFSET_BITS +: INDEX_BITS];
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        buf_reg <= rd_data;
                    end else if (miss) begin
                        victim_reg     <= sel_victim;
                        victim_ptr_reg <= sel_from_ptr;
                    end
                end
                MEM_WAIT: begin
                    if (mem_rsp_valid) begin
                        buf_reg <= mem_rsp_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign lookup_tag   = lookup_tag_reg;
    assign lookup_index = lookup_index_reg;
    assign mem_req_addr = {lookup_tag_reg, lookup_index_reg, {OFFSET_BITS{1'b0}}};
    assign cpu_rsp_data = buf_reg;
    assign fill_way     = victim_reg;
    assign fill_index   = lookup_index_reg;
    assign fill_tag     = lookup_tag_reg;
    assign fill_data    = buf_reg;

endmodule
